multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared single-ALU, single-memory RISC-V datapath across multiple cycles per instruction.
- Supports load (0000011), R-type (0110011), branch (1100011) and store (0100011).
- Adds a memory-ready handshake with wait states, a timeout trap, and a sticky illegal-opcode trap.
- Sits between the instruction register opcode field and the datapath mux selects and write enables.

Parameters:
- MEM_TIMEOUT, 15, max consecutive wait cycles in a memory state before trap; 0 disables timeout.
- CNT_W, 32, width of optional retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  7  instr[6:0] from instruction register (valid from DECODE onward)
- mem_ready  input  1  memory completes current read/write this cycle
- pc_write  output  1  unconditional PC update
- pc_write_cond  output  1  PC update if ALU zero
- pc_source  output  1  0=ALU result, 1=ALUOut register (branch target)
- ir_write  output  1  latch instruction register
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- mem_to_reg  output  1  writeback select, 1=memory data
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0=PC, 1=rs1
- alu_src_b  output  2  00=rs2, 01=constant 4, 10=immediate
- alu_op  output  2  00=add, 01=subtract/compare, 10=funct-decoded
- state_o  output  4  current state encoding (debug)
- trap  output  1  sticky fault flag
- instret  output  CNT_W  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_ADDR, EXEC_BR, MEM_RD, MEM_WR, WB_R, WB_MEM, TRAP. Encodings 0..9 in that order.
- Reset: state=FETCH, trap=0, timeout counter=0, instret=0. After reset, outputs equal FETCH decode. Reset in any state, including TRAP or mid-wait, aborts the instruction and takes effect at the next edge.
- Default for any output not listed below: 0.
- FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready (combinational gate). On mem_ready go to DECODE, else hold.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (precomputes branch target).
  - Load/store go to EXEC_ADDR; R-type to EXEC_R; branch to EXEC_BR.
  - Any other opcode goes to TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB_R.
- WB_R: reg_write=1, mem_to_reg=0; next FETCH.
- EXEC_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Load goes to MEM_RD, store to MEM_WR. The opcode is re-sampled here and the IR must stay stable.
- MEM_RD: mem_read=1; on mem_ready go to WB_MEM, else hold.
- WB_MEM: reg_write=1, mem_to_reg=1; next FETCH.
- MEM_WR: mem_write=1; on mem_ready go to FETCH, else hold.
- EXEC_BR: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1; next FETCH.
- TRAP: all strobes 0, trap=1. Held until reset.
- Zero-wait latency (cycles per instruction): R-type 4, load 5, store 4, branch 3. Each wait cycle in FETCH/MEM_RD/MEM_WR adds 1.
- Timeout counter:
  - Cleared on entry to any memory state and in all non-memory states.
  - Increments each cycle spent in a memory state with mem_ready=0, saturating.
  - If the counter equals MEM_TIMEOUT and mem_ready=0, the next state is TRAP.
  - mem_ready=1 on that same cycle wins: normal transition, no trap.
  - MEM_TIMEOUT=0 means no timeout is ever raised.

Optional Feature:
- Macro: MULTICYCLE_INSTRET_EN.
- With macro: instret increments by 1 on every retiring transition into FETCH: from WB_R, WB_MEM, EXEC_BR, and MEM_WR with mem_ready. It wraps modulo 2^CNT_W and does not increment in TRAP.
- Without macro: instret is tied to 0 and no counter flops are present.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_LOAD, OP_RTYPE, OP_BRANCH, OP_STORE;
  - ALUOp encodings ALU_ADD, ALU_SUB, ALU_FUNCT;
  - alu_src_b encodings SRCB_RS2, SRCB_FOUR, SRCB_IMM.
- One sub-module, mem_wait_timer, owns the timeout counter, parameterized by MEM_TIMEOUT, with inputs clear, waiting and output expired.

Test Plan:
- Reset, then R-type with mem_ready held 1: state_o sequence 0,1,2,7,0. reg_write=1 only in the WB_R cycle. instret=1 with macro.
- Load with mem_ready low for 3 cycles in MEM_RD: sequence FETCH, DECODE, EXEC_ADDR, MEM_RD×4, WB_MEM. mem_to_reg=1 and reg_write=1 in WB_MEM; 8 cycles total.
- Store followed by beq, zero-wait: mem_write=1 exactly 1 cycle; pc_write_cond=pc_source=1 exactly 1 cycle in EXEC_BR. instret=2.
- Opcode 0010011 at DECODE: next state TRAP, trap=1 sticky for 20 cycles with all strobes 0. Reset returns to FETCH with trap=0.
- MEM_TIMEOUT=15, mem_ready stuck 0 in FETCH: TRAP entered on the 17th cycle after FETCH entry. Repeat with mem_ready=1 on the 16th cycle: DECODE entered, no trap.
- Reset asserted during MEM_WR wait: next state FETCH, mem_write=0, instret unchanged.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state encoding,
// opcode constants and datapath select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_ADDR = 4'd3,
    ST_EXEC_BR   = 4'd4,
    ST_MEM_RD    = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_WB_R      = 4'd7,
    ST_WB_MEM    = 4'd8,
    ST_TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States that talk to memory and may be stretched by wait cycles.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts consecutive memory wait cycles; raises expired once the count
// reaches MEM_TIMEOUT. MEM_TIMEOUT = 0 disables expiry entirely.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] count_reg;

  // Saturating wait counter; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (waiting && (count_reg != LIMIT)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (count_reg == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared single-ALU, single-memory RISC-V datapath.
// Handles load/store/R-type/branch, memory wait states with a timeout trap
// and a sticky illegal-opcode trap.
// Optional retired-instruction counter: define MULTICYCLE_INSTRET_EN.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state_o,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t state_reg;
  state_t state_next;

  logic in_mem;
  logic waiting;
  logic timer_clear;
  logic expired;
  logic timeout_hit;

  assign in_mem      = is_mem_state(state_reg);
  assign waiting     = in_mem && !mem_ready;
  // Restart the count on every state change and outside memory states, so
  // each memory state entry starts from zero.
  assign timer_clear = !in_mem || (state_next != state_reg);
  assign timeout_hit = expired && waiting;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .waiting(waiting),
    .expired(expired)
  );

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Moore outputs (FETCH gates ir/pc write with mem_ready).
  always_comb begin
    state_next    = state_reg;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    trap          = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)        state_next = ST_DECODE;
        else if (timeout_hit) state_next = ST_TRAP;
      end
      ST_DECODE: begin
        // ALU precomputes the branch target PC + imm into ALUOut.
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = ST_EXEC_ADDR;
          OP_RTYPE:          state_next = ST_EXEC_R;
          OP_BRANCH:         state_next = ST_EXEC_BR;
          default:           state_next = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_FUNCT;
        state_next = ST_WB_R;
      end
      ST_WB_R: begin
        reg_write  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_EXEC_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LOAD)       state_next = ST_MEM_RD;
        else if (opcode == OP_STORE) state_next = ST_MEM_WR;
        else                         state_next = ST_TRAP;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready)        state_next = ST_WB_MEM;
        else if (timeout_hit) state_next = ST_TRAP;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready)        state_next = ST_FETCH;
        else if (timeout_hit) state_next = ST_TRAP;
      end
      ST_EXEC_BR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        state_next    = ST_FETCH;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_next = ST_TRAP;
      end
    endcase
  end

  assign state_o = state_reg;

`ifdef MULTICYCLE_INSTRET_EN
  logic             retire;
  logic [CNT_W-1:0] instret_reg;

  assign retire = (state_reg == ST_WB_R) || (state_reg == ST_WB_MEM) ||
                  (state_reg == ST_EXEC_BR) ||
                  ((state_reg == ST_MEM_WR) && mem_ready);

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_reg <= '0;
    end else if (retire) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign instret = instret_reg;
`else
  assign instret = {CNT_W{1'b0}};
`endif

endmodule
